alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, 0, 0 = round-robin grant; 1 = requester 0 always wins ties.
REQ-002 i_clk  input  1  single clock; all state changes on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req_valid_0 / i_req_valid_1  input  1  requester k has an operation pending.
REQ-005 o_req_ready_0 / o_req_ready_1  output  1  operation of requester k accepted this cycle.
REQ-006 i_opA_k, i_opB_k  input  32  operands of requester k.
REQ-007 i_control_k  input  4  ALU op code of requester k (ADD=0, SUB=1, AND=2, OR=3, NOR=4, XOR=5, SLL=6, SRL=7, SLTU=8).
REQ-008 i_shift_k  input  5  shift amount of requester k.
REQ-009 o_rsp_valid_0 / o_rsp_valid_1  output  1  result for requester k available.
REQ-010 i_rsp_ready_0 / i_rsp_ready_1  input  1  requester k consumes its result.
REQ-011 o_result_k  output  32, o_zf_k  output  1  registered result and zero flag for requester k.
REQ-012 o_alu_opA, o_alu_opB  output  32; o_alu_control  output  4; o_alu_shift  output  5  drive the shared ALU.
REQ-013 i_alu_result  input  32; i_alu_zf  input  1  combinational ALU outputs.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: if any i_req_valid_k high, arbiter SHALL select one winner combinationally and assert only that requester's o_req_ready_k; no ready in EXEC/RESP.
REQ-016 Handshake: transfer occurs when valid && ready; operands, control, shift and winner ID SHALL be latched on that edge; FSM -> EXEC.
REQ-017 Round-robin: winner SHALL be requester not granted last when both valid; single valid requester always wins; last-grant pointer updates at acceptance; reset value points to requester 1 (so requester 0 wins first).
REQ-018 FIXED_PRIO=1: requester 0 SHALL win whenever i_req_valid_0 high.
REQ-019 o_alu_* SHALL always reflect the latched registers (not requester inputs); control and shift passed unmodified, including undefined codes 9-15.
REQ-020 EXEC (exactly one cycle): i_alu_result and i_alu_zf SHALL be captured into result registers; FSM -> RESP.
REQ-021 RESP: o_rsp_valid of the latched winner only SHALL be high; o_result_k/o_zf_k of that requester show captured values, held stable until the matching i_rsp_ready_k high.
REQ-022 RESP with matching i_rsp_ready_k high: FSM -> IDLE on that edge; o_rsp_valid drops next cycle.
REQ-023 i_rsp_ready of the non-granted requester SHALL be ignored; i_req_valid changes during EXEC/RESP SHALL not affect the operation in flight.
REQ-024 Latency: acceptance at edge N -> o_rsp_valid high from cycle after edge N+1; peak throughput one operation per 3 cycles.
REQ-025 o_result_k/o_zf_k of a requester not currently in RESP SHALL read 0.

Reset
REQ-026 i_rst_n low SHALL immediately (asynchronously) force: state IDLE, all o_req_ready 0, all o_rsp_valid 0, o_result_k 0, o_zf_k 0, o_alu_opA/opB 0, o_alu_control 0, o_alu_shift 0, last-grant pointer = 1.
REQ-027 Reset asserted mid-EXEC or mid-RESP SHALL discard the in-flight operation; no response delivered after release.
REQ-028 After i_rst_n deasserts, first acceptance possible on first rising edge with a valid request.

Verification
REQ-029 Req0 ADD 5,7 alone, rsp_ready_0=1 -> o_req_ready_0 in accept cycle, o_rsp_valid_0 two cycles later, o_result_0=12, o_zf_0=0; o_rsp_valid_1 stays 0.
REQ-030 Both valid from reset, req0 SUB 9,9, req1 SLL B=1 shift=4, FIXED_PRIO=0 -> req0 served first (result 0, zf 1), then req1 (result 0x10, zf 0); next tie grants req0.
REQ-031 FIXED_PRIO=1, both valid continuously for 3 ops -> req0 granted all 3, req1 never ready.
REQ-032 Req1 NOR 0,0 with i_rsp_ready_1 low 5 cycles -> o_result_1=0xFFFFFFFF held 5+ cycles, no o_req_ready on either port until consumed.
REQ-033 Reset pulsed during EXEC of req0 ADD 1,1 -> all outputs 0 immediately, no o_rsp_valid_0 after release; next request completes normally.
REQ-034 Req0 control=4'd12 -> o_alu_control=12 during EXEC, captured i_alu_result returned unmodified.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, latches the
// winning operation, captures the ALU result and holds it until the requester consumes it.
module alu_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid_0,
   input  logic        i_req_valid_1,
   output logic        o_req_ready_0,
   output logic        o_req_ready_1,
   input  logic [31:0] i_opA_0,
   input  logic [31:0] i_opB_0,
   input  logic [31:0] i_opA_1,
   input  logic [31:0] i_opB_1,
   input  logic [3:0]  i_control_0,
   input  logic [3:0]  i_control_1,
   input  logic [4:0]  i_shift_0,
   input  logic [4:0]  i_shift_1,
   output logic        o_rsp_valid_0,
   output logic        o_rsp_valid_1,
   input  logic        i_rsp_ready_0,
   input  logic        i_rsp_ready_1,
   output logic [31:0] o_result_0,
   output logic [31:0] o_result_1,
   output logic        o_zf_0,
   output logic        o_zf_1,
   output logic [31:0] o_alu_opA,
   output logic [31:0] o_alu_opB,
   output logic [3:0]  o_alu_control,
   output logic [4:0]  o_alu_shift,
   input  logic [31:0] i_alu_result,
   input  logic        i_alu_zf
);

   // state | meaning
   // IDLE  | waiting for a request; ready offered to the arbitration winner
   // EXEC  | latched operation drives the ALU; result captured at the edge
   // RESP  | result presented to the winner until it asserts rsp_ready
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        win_q, win_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [4:0]  shift_q, shift_d;
   logic [31:0] res_q, res_d;
   logic        zf_q, zf_d;

   logic any_req;
   logic winner;
   logic accept;
   logic rsp_ack;

   always_comb begin
      any_req = i_req_valid_0 | i_req_valid_1;
      if (FIXED_PRIO)
         winner = ~i_req_valid_0;
      else if (i_req_valid_0 && i_req_valid_1)
         winner = ~last_q;
      else
         winner = ~i_req_valid_0;
      // ready must read 0 while reset is held, even though state is already IDLE
      accept  = (state_q == IDLE) && any_req && i_rst_n;
      rsp_ack = win_q ? i_rsp_ready_1 : i_rsp_ready_0;

      state_d = state_q;
      last_d  = last_q;
      win_d   = win_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      ctrl_d  = ctrl_q;
      shift_d = shift_q;
      res_d   = res_q;
      zf_d    = zf_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               opa_d   = winner ? i_opA_1 : i_opA_0;
               opb_d   = winner ? i_opB_1 : i_opB_0;
               ctrl_d  = winner ? i_control_1 : i_control_0;
               shift_d = winner ? i_shift_1 : i_shift_0;
               win_d   = winner;
               last_d  = winner;
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_d   = i_alu_result;
            zf_d    = i_alu_zf;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         win_q   <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         ctrl_q  <= '0;
         shift_q <= '0;
         res_q   <= '0;
         zf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         ctrl_q  <= ctrl_d;
         shift_q <= shift_d;
         res_q   <= res_d;
         zf_q    <= zf_d;
      end
   end

   always_comb begin
      o_req_ready_0 = accept && !winner;
      o_req_ready_1 = accept && winner;
      o_rsp_valid_0 = (state_q == RESP) && !win_q;
      o_rsp_valid_1 = (state_q == RESP) && win_q;
      o_result_0    = o_rsp_valid_0 ? res_q : '0;
      o_result_1    = o_rsp_valid_1 ? res_q : '0;
      o_zf_0        = o_rsp_valid_0 && zf_q;
      o_zf_1        = o_rsp_valid_1 && zf_q;
      o_alu_opA     = opa_q;
      o_alu_opB     = opb_q;
      o_alu_control = ctrl_q;
      o_alu_shift   = shift_q;
   end

endmodule
